// File: rtl/spi_obi_arbiter_if.sv
// Bus bundle between two OBI requesters, the arbiter and the SPI peripheral slave port.
// Signal suffixes are as seen from the arbiter; "slave" is the arbiter side, "master" the environment.
interface spi_obi_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                  m_req_i;
    logic [1:0]                  m_gnt_o;
    logic [2*ADDR_WIDTH-1:0]     m_addr_i;
    logic [1:0]                  m_we_i;
    logic [2*DATA_WIDTH/8-1:0]   m_be_i;
    logic [2*DATA_WIDTH-1:0]     m_wdata_i;
    logic [1:0]                  m_rvalid_o;
    logic [DATA_WIDTH-1:0]       m_rdata_o;
    logic                        s_req_o;
    logic                        s_gnt_i;
    logic [ADDR_WIDTH-1:0]       s_addr_o;
    logic                        s_we_o;
    logic [DATA_WIDTH/8-1:0]     s_be_o;
    logic [DATA_WIDTH-1:0]       s_wdata_o;
    logic                        s_rvalid_i;
    logic [DATA_WIDTH-1:0]       s_rdata_i;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );
endinterface

// File: rtl/spi_obi_arbiter.sv
// Round-robin two-port OBI arbiter in front of the SPI peripheral, with request lock
// and an in-order FIFO of granted IDs that steers responses back to their requester.
module spi_obi_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    spi_obi_arbiter_if.slave   bus,
    output logic               err_o,
    output logic [0:0]         state_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    localparam logic [0:0] ST_FREE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             lock_id_q, lock_id_d;
    logic             ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic             fifo_q [MAX_OUTSTANDING];

    logic sel, fifo_full, fifo_empty, handshake, pop, head;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Full uses the registered count, so a same-cycle pop cannot reopen the request path.
    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_q];

    always_comb begin
        sel = ptr_q;
        if (state_q == ST_LOCKED)      sel = lock_id_q;
        else if (bus.m_req_i[ptr_q])   sel = ptr_q;
        else if (bus.m_req_i[~ptr_q])  sel = ~ptr_q;
    end

    assign bus.s_req_o   = !rst_i && bus.m_req_i[sel] && !fifo_full;
    assign handshake     = bus.s_req_o && bus.s_gnt_i;
    assign bus.m_gnt_o   = handshake ? (sel ? 2'b10 : 2'b01) : 2'b00;

    assign bus.s_addr_o  = sel ? bus.m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.m_addr_i[ADDR_WIDTH-1:0];
    assign bus.s_we_o    = bus.m_we_i[sel];
    assign bus.s_be_o    = sel ? bus.m_be_i[2*BE_W-1:BE_W] : bus.m_be_i[BE_W-1:0];
    assign bus.s_wdata_o = sel ? bus.m_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.m_wdata_i[DATA_WIDTH-1:0];

    assign pop            = !rst_i && bus.s_rvalid_i && !fifo_empty;
    assign bus.m_rvalid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
    assign bus.m_rdata_o  = bus.s_rdata_i;

    assign err_o   = err_q;
    assign state_o = state_q;

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        err_d     = err_q;
        cnt_d     = cnt_q + CNT_W'(handshake) - CNT_W'(pop);
        case (state_q)
            ST_FREE: begin
                if (bus.s_req_o && !bus.s_gnt_i) begin
                    state_d   = ST_LOCKED;
                    lock_id_d = sel;
                end
            end
            default: begin
                if (handshake) state_d = ST_FREE;
            end
        endcase
        if (handshake) begin
            wr_d  = wrap_inc(wr_q);
            ptr_d = ~sel;
        end
        if (pop) rd_d = wrap_inc(rd_q);
        if (bus.s_rvalid_i && fifo_empty) err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FREE;
            lock_id_q <= 1'b0;
            ptr_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            if (handshake) fifo_q[wr_q] <= sel;
        end
    end
endmodule
